ucore_mailbox: RTL and testbench

Host-side endpoint for a generated microcoded core (ucore_*).
- Host issues commands over a valid/ready stream. The mailbox delivers each one to the core's input ports using a four-phase req/ack handshake.
- Responses raised by the core on its registered output ports come back over a four-phase handshake, are buffered in a small FIFO, and are returned to the host as a valid/ready stream.
- Sits between a bus/testbench host and one ucore instance.

---
 rtl/ucore_mailbox_pkg.sv | 34 +++
 rtl/ucore_mailbox_fifo.sv | 75 +++++++
 rtl/ucore_mailbox.sv | 199 +++++++++++++++++++
 tb/tb_ucore_mailbox.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucore_mailbox_pkg.sv
// rtl/ucore_mailbox_pkg.sv - shared state encodings and helpers for ucore_mailbox
//
// Contents:
//   cmd_state_e : command handshake FSM states (C_IDLE, C_REQ, C_REL)
//   rsp_state_e : response handshake FSM states (R_IDLE, R_ACK)
//   clog2()     : ceiling log2, usable in constant expressions

package ucore_mailbox_pkg;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_REQ  = 2'd1,
    C_REL  = 2'd2
  } cmd_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rsp_state_e;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ucore_mailbox_fifo.sv
// rtl/ucore_mailbox_fifo.sv - synchronous response FIFO for ucore_mailbox
//
// Ports:
//   clk, aresetn : clock, asynchronous active-low reset
//   push         : write push_data (ignored when full)
//   push_data    : DATA_W write word
//   pop          : advance read pointer (ignored when empty)
//   pop_data     : DATA_W head word, combinational from the storage array
//   full, empty  : occupancy flags decoded from the pointers

module ucore_mailbox_fifo
  import ucore_mailbox_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the low bits match.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              push_en;
  logic              pop_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Full is the registered flag, so a pop in the same cycle never opens room
  // for a push: the producer simply retries next cycle.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ucore_mailbox.sv
// rtl/ucore_mailbox.sv - host-side command/response mailbox for a ucore instance
//
// Optional build macro: UCORE_MAILBOX_TIMEOUT_EN adds a command-ack watchdog
// and the sticky err_timeout output.
//
// Ports:
//   clk, aresetn                          : clock, asynchronous active-low reset
//   host_cmd_valid/ready/data             : host command stream in
//   host_rsp_valid/ready/data             : host response stream out (FIFO head)
//   core_cmd_req/data, core_cmd_ack       : four-phase command transfer to the core
//   core_rsp_req/data, core_rsp_ack       : four-phase response transfer from the core
//   err_timeout (macro only)              : command ack watchdog fired, sticky

module ucore_mailbox
  import ucore_mailbox_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RSP_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              host_cmd_valid,
  output logic              host_cmd_ready,
  input  logic [DATA_W-1:0] host_cmd_data,
  output logic              host_rsp_valid,
  input  logic              host_rsp_ready,
  output logic [DATA_W-1:0] host_rsp_data,
  output logic              core_cmd_req,
  output logic [DATA_W-1:0] core_cmd_data,
  input  logic              core_cmd_ack,
  input  logic              core_rsp_req,
  input  logic [DATA_W-1:0] core_rsp_data,
  output logic              core_rsp_ack
`ifdef UCORE_MAILBOX_TIMEOUT_EN
  ,
  output logic              err_timeout
`endif
);

  // ---------------------------------------------------------------------------
  // Command path
  // ---------------------------------------------------------------------------
  cmd_state_e        cmd_state_q, cmd_state_d;
  logic              cmd_req_q, cmd_req_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;

`ifdef UCORE_MAILBOX_TIMEOUT_EN
  localparam int            TW       = clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_timeout_q, err_timeout_d;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  always_comb begin
    cmd_state_d    = cmd_state_q;
    cmd_req_d      = cmd_req_q;
    cmd_data_d     = cmd_data_q;
    host_cmd_ready = 1'b0;
`ifdef UCORE_MAILBOX_TIMEOUT_EN
    // Counter only runs while waiting for ack; any other state parks it at 0.
    tmo_cnt_d      = '0;
    err_timeout_d  = err_timeout_q;
`endif
    case (cmd_state_q)
      C_IDLE: begin
        // A stale ack seen here is ignored; only C_REL waits on its release.
        host_cmd_ready = 1'b1;
        if (host_cmd_valid) begin
          cmd_data_d  = host_cmd_data;
          cmd_req_d   = 1'b1;
          cmd_state_d = C_REQ;
        end
      end
      C_REQ: begin
        if (core_cmd_ack) begin
          cmd_req_d   = 1'b0;
          cmd_state_d = C_REL;
        end
`ifdef UCORE_MAILBOX_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          // Core never answered: abandon the command and flag it.
          cmd_req_d     = 1'b0;
          err_timeout_d = 1'b1;
          cmd_state_d   = C_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      C_REL: begin
        if (!core_cmd_ack) begin
          cmd_state_d = C_IDLE;
        end
      end
      default: begin
        cmd_req_d   = 1'b0;
        cmd_state_d = C_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_state_q <= C_IDLE;
      cmd_req_q   <= 1'b0;
      cmd_data_q  <= '0;
    end else begin
      cmd_state_q <= cmd_state_d;
      cmd_req_q   <= cmd_req_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

`ifdef UCORE_MAILBOX_TIMEOUT_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`endif

  assign core_cmd_req  = cmd_req_q;
  assign core_cmd_data = cmd_data_q;

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  rsp_state_e rsp_state_q, rsp_state_d;
  logic       rsp_ack_q, rsp_ack_d;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;

  always_comb begin
    rsp_state_d = rsp_state_q;
    rsp_ack_d   = rsp_ack_q;
    fifo_push   = 1'b0;
    case (rsp_state_q)
      R_IDLE: begin
        // Holding ack low while full keeps the core's word on its port.
        if (core_rsp_req && !fifo_full) begin
          fifo_push   = 1'b1;
          rsp_ack_d   = 1'b1;
          rsp_state_d = R_ACK;
        end
      end
      R_ACK: begin
        if (!core_rsp_req) begin
          rsp_ack_d   = 1'b0;
          rsp_state_d = R_IDLE;
        end
      end
      default: begin
        rsp_ack_d   = 1'b0;
        rsp_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_state_q <= R_IDLE;
      rsp_ack_q   <= 1'b0;
    end else begin
      rsp_state_q <= rsp_state_d;
      rsp_ack_q   <= rsp_ack_d;
    end
  end

  assign core_rsp_ack   = rsp_ack_q;
  assign host_rsp_valid = !fifo_empty;
  assign fifo_pop       = host_rsp_valid && host_rsp_ready;

  ucore_mailbox_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .push      (fifo_push),
    .push_data (core_rsp_data),
    .pop       (fifo_pop),
    .pop_data  (host_rsp_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ucore_mailbox.sv
// tb/tb_ucore_mailbox.sv - scoreboard bench for ucore_mailbox

module tb_ucore_mailbox;

  localparam int DATA_W      = 32;
  localparam int RSP_DEPTH   = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int LIMIT       = 2000;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic              host_cmd_valid = 1'b0;
  logic              host_cmd_ready;
  logic [DATA_W-1:0] host_cmd_data = '0;
  logic              host_rsp_valid;
  logic              host_rsp_ready = 1'b0;
  logic [DATA_W-1:0] host_rsp_data;
  logic              core_cmd_req;
  logic [DATA_W-1:0] core_cmd_data;
  logic              core_cmd_ack = 1'b0;
  logic              core_rsp_req = 1'b0;
  logic [DATA_W-1:0] core_rsp_data = '0;
  logic              core_rsp_ack;
`ifdef UCORE_MAILBOX_TIMEOUT_EN
  logic              err_timeout;
`endif

  always #5 clk = ~clk;

  ucore_mailbox #(
    .DATA_W      (DATA_W),
    .RSP_DEPTH   (RSP_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .host_cmd_valid (host_cmd_valid),
    .host_cmd_ready (host_cmd_ready),
    .host_cmd_data  (host_cmd_data),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_ready (host_rsp_ready),
    .host_rsp_data  (host_rsp_data),
    .core_cmd_req   (core_cmd_req),
    .core_cmd_data  (core_cmd_data),
    .core_cmd_ack   (core_cmd_ack),
    .core_rsp_req   (core_rsp_req),
    .core_rsp_data  (core_rsp_data),
    .core_rsp_ack   (core_rsp_ack)
`ifdef UCORE_MAILBOX_TIMEOUT_EN
    ,
    .err_timeout    (err_timeout)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: commands must reach the core in host acceptance order;
  // responses must reach the host in core acknowledge order.
  logic [DATA_W-1:0] cmd_q[$];
  logic [DATA_W-1:0] rsp_q[$];
  int                rsp_pops = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Command monitor: each rising core_cmd_req must carry the next accepted word.
  logic req_seen = 1'b0;
  always @(negedge clk) begin
    if (!aresetn) begin
      req_seen <= 1'b0;
    end else begin
      if (core_cmd_req && !req_seen) begin
        chk("cmd_expected", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) chk("cmd_data", core_cmd_data, cmd_q.pop_front());
      end
      if (core_cmd_req) chk("cmd_ready_low", host_cmd_ready, 0);
      req_seen <= core_cmd_req;
    end
  end

  // Response monitor: valid must track model occupancy; each pop must match the head.
  always @(negedge clk) begin
    #1;
    if (aresetn) begin
      chk("rsp_valid", host_rsp_valid, rsp_q.size() != 0);
      if (host_rsp_valid && host_rsp_ready && rsp_q.size() != 0) begin
        chk("rsp_data", host_rsp_data, rsp_q.pop_front());
        rsp_pops++;
      end
    end
  end

  // Host offers one command; returns on the negedge after it was taken.
  task automatic send_cmd(input logic [DATA_W-1:0] d);
    int n = 0;
    host_cmd_valid = 1'b1;
    host_cmd_data  = d;
    while (!host_cmd_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_bound", n < LIMIT, 1);
    if (n < LIMIT) cmd_q.push_back(d);
    @(negedge clk);
    host_cmd_valid = 1'b0;
  endtask

  // Core side of one command handshake.
  task automatic core_serve_cmd(input int dly_ack, input int dly_rel);
    int n = 0;
    while (!core_cmd_req && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("core_req_bound", n < LIMIT, 1);
    repeat (dly_ack) @(negedge clk);
    core_cmd_ack = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (core_cmd_req && n < LIMIT);
    chk("core_req_release", core_cmd_req, 0);
    repeat (dly_rel) @(negedge clk);
    core_cmd_ack = 1'b0;
  endtask

  // Core side of one response handshake.
  task automatic core_send_rsp(input logic [DATA_W-1:0] d, input int dly_rel);
    int n = 0;
    core_rsp_req  = 1'b1;
    core_rsp_data = d;
    do begin
      @(negedge clk);
      n++;
    end while (!core_rsp_ack && n < LIMIT);
    chk("rsp_ack_bound", core_rsp_ack, 1);
    if (core_rsp_ack) rsp_q.push_back(d);
    repeat (dly_rel) @(negedge clk);
    core_rsp_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (core_rsp_ack && n < LIMIT);
    chk("rsp_ack_release", core_rsp_ack, 0);
  endtask

  task automatic drain_rsp();
    int n = 0;
    host_rsp_ready = 1'b1;
    while (rsp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    host_rsp_ready = 1'b0;
    chk("drain_bound", rsp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    int cyc;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_cmd_req", core_cmd_req, 0);
    chk("rst_cmd_data", core_cmd_data, 0);
    chk("rst_rsp_ack", core_rsp_ack, 0);
    chk("rst_rsp_valid", host_rsp_valid, 0);
    chk("rst_rsp_data", host_rsp_data, 0);
`ifdef UCORE_MAILBOX_TIMEOUT_EN
    chk("rst_err_timeout", err_timeout, 0);
`endif
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", host_cmd_ready, 1);

    // Directed command handshake timing.
    host_cmd_valid = 1'b1;
    host_cmd_data  = 32'hA5A5_0001;
    cmd_q.push_back(32'hA5A5_0001);
    @(negedge clk);
    host_cmd_valid = 1'b0;
    chk("a5_req", core_cmd_req, 1);
    chk("a5_data", core_cmd_data, 32'hA5A5_0001);
    chk("a5_ready", host_cmd_ready, 0);
    repeat (4) @(negedge clk);
    chk("a5_req_hold", core_cmd_req, 1);
    core_cmd_ack = 1'b1;
    @(negedge clk);
    chk("a5_req_fall", core_cmd_req, 0);
    chk("a5_rel_ready", host_cmd_ready, 0);
    core_cmd_ack = 1'b0;
    @(negedge clk);
    chk("a5_ready_back", host_cmd_ready, 1);

    // FIFO full back-pressure.
    for (int i = 0; i < 4; i++) core_send_rsp(32'h10 + i, 0);
    core_rsp_req  = 1'b1;
    core_rsp_data = 32'h14;
    repeat (5) @(negedge clk);
    chk("full_no_ack", core_rsp_ack, 0);
    host_rsp_ready = 1'b1;
    @(negedge clk);
    host_rsp_ready = 1'b0;
    chk("full_pop_cycle_no_ack", core_rsp_ack, 0);
    @(negedge clk);
    chk("full_ack_after_pop", core_rsp_ack, 1);
    rsp_q.push_back(32'h14);
    core_rsp_req = 1'b0;
    @(negedge clk);
    chk("full_ack_drop", core_rsp_ack, 0);
    target = rsp_pops + 4;
    drain_rsp();
    chk("full_pop_count", rsp_pops, target);

    // Simultaneous push and pop at occupancy 2.
    core_send_rsp(32'h20, 0);
    core_send_rsp(32'h21, 0);
    for (int i = 0; i < 5; i++) begin
      core_rsp_req   = 1'b1;
      core_rsp_data  = 32'h22 + i;
      host_rsp_ready = 1'b1;
      @(negedge clk);
      host_rsp_ready = 1'b0;
      chk("pp_ack", core_rsp_ack, 1);
      rsp_q.push_back(32'h22 + i);
      core_rsp_req = 1'b0;
      @(negedge clk);
      chk("pp_ack_drop", core_rsp_ack, 0);
    end
    host_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    host_rsp_ready = 1'b0;
    chk("pp_empty_after_two", host_rsp_valid, 0);

    // Reset in the middle of both handshakes with two responses buffered.
    core_send_rsp(32'h30, 0);
    core_send_rsp(32'h31, 0);
    core_rsp_req  = 1'b1;
    core_rsp_data = 32'h32;
    send_cmd(32'hC0DE_0001);
    chk("mid_rsp_ack_pre", core_rsp_ack, 1);
    chk("mid_cmd_req_pre", core_cmd_req, 1);
    #2;
    aresetn      = 1'b0;
    core_rsp_req = 1'b0;
    rsp_q.delete();
    cmd_q.delete();
    #1;
    chk("mid_cmd_req", core_cmd_req, 0);
    chk("mid_rsp_ack", core_rsp_ack, 0);
    chk("mid_rsp_valid", host_rsp_valid, 0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk("mid_ready", host_cmd_ready, 1);

    // Randomised concurrent traffic on both paths.
    target = rsp_pops + 30;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send_cmd($urandom);
        end
      end
      begin
        for (int i = 0; i < 25; i++) core_serve_cmd($urandom_range(0, 4), $urandom_range(0, 3));
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          core_send_rsp($urandom, $urandom_range(0, 2));
        end
      end
      begin
        int n = 0;
        while (rsp_pops < target && n < 4 * LIMIT) begin
          host_rsp_ready = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          n++;
        end
        host_rsp_ready = 1'b0;
        chk("rnd_rsp_count", rsp_pops, target);
      end
    join
    chk("rnd_cmd_left", cmd_q.size(), 0);

`ifdef UCORE_MAILBOX_TIMEOUT_EN
    // Watchdog: core never acks.
    send_cmd(32'h7777_0001);
    cyc = 0;
    while (core_cmd_req && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", cyc, TIMEOUT_CYC);
    chk("tmo_err", err_timeout, 1);
    chk("tmo_ready", host_cmd_ready, 1);
    fork
      send_cmd(32'h7777_0002);
      core_serve_cmd(1, 1);
    join
    repeat (2) @(negedge clk);
    chk("tmo_err_sticky", err_timeout, 1);
`else
    cyc = 0;
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
